// File: rtl/seg7_scan_decoder_if.sv
// Bundle between a multiplexed 7-segment display drive and its frame decoder.
// master: the display drive side; slave: the decoder.
interface seg7_scan_decoder_if;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] digits;
  logic [3:0]  dash;
  logic        valid;
  logic        err;
  logic [1:0]  err_digit;

  modport master (
    output seg_n, an_n,
    input  digits, dash, valid, err, err_digit
  );

  modport slave (
    input  seg_n, an_n,
    output digits, dash, valid, err, err_digit
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 7-segment display, debounces each scanned digit and
// publishes a complete four-digit frame once every digit has been captured.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  seg7_scan_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    PAT_BAD,
    PAT_DIGIT,
    PAT_DASH
  } pat_kind_e;

  localparam logic [7:0] ACCEPT_AT = 8'(STABLE_CYCLES - 1);

  logic [10:0] sample_q, sample_d;
  logic [7:0]  stable_q, stable_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_dash_q, shadow_dash_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dash_q, dash_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [1:0]  err_digit_q, err_digit_d;

  logic [3:0]  sel;
  logic [6:0]  pattern;
  logic        one_active;
  logic [1:0]  digit_idx;
  logic        accept;
  pat_kind_e   pat_kind;
  logic [3:0]  pat_val;

  // Sample register and stable-period counter; the counter restarts on any
  // change of {an_n, seg_n}, so a segment-only change needs a new period.
  always_comb begin
    sample_d = {bus.an_n, bus.seg_n};
    if (sample_d != sample_q) begin
      stable_d = '0;
    end else if (stable_q != '1) begin
      stable_d = stable_q + 8'd1;
    end else begin
      stable_d = stable_q;
    end
  end

  assign sel        = ~sample_q[10:7];
  assign pattern    = ~sample_q[6:0];
  assign one_active = (sel != '0) && ((sel & (sel - 4'd1)) == '0);

  always_comb begin
    digit_idx = '0;
    case (sel)
      4'b0001: digit_idx = 2'd0;
      4'b0010: digit_idx = 2'd1;
      4'b0100: digit_idx = 2'd2;
      4'b1000: digit_idx = 2'd3;
      default: digit_idx = '0;
    endcase
  end

  // Equality rather than >= so a saturated counter never re-accepts.
  assign accept = one_active && (stable_q == ACCEPT_AT);

  always_comb begin
    pat_kind = PAT_DIGIT;
    pat_val  = '0;
    case (pattern)
      7'b0111111: pat_val = 4'd0;
      7'b0000110: pat_val = 4'd1;
      7'b1011011: pat_val = 4'd2;
      7'b1001111: pat_val = 4'd3;
      7'b1100110: pat_val = 4'd4;
      7'b1101101: pat_val = 4'd5;
      7'b1111101: pat_val = 4'd6;
      7'b0000111: pat_val = 4'd7;
      7'b1111111: pat_val = 4'd8;
      7'b1101111: pat_val = 4'd9;
      7'b1000000: begin
        pat_kind = PAT_DASH;
        pat_val  = 4'hF;
      end
      default:    pat_kind = PAT_BAD;
    endcase
  end

  // The completing capture is folded into the same edge as the frame copy,
  // so valid rises on the edge that would otherwise register the capture.
  always_comb begin
    shadow_d      = shadow_q;
    shadow_dash_d = shadow_dash_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    dash_d        = dash_q;
    valid_d       = 1'b0;
    err_d         = 1'b0;
    err_digit_d   = err_digit_q;
    if (accept) begin
      if (pat_kind == PAT_BAD) begin
        err_d       = 1'b1;
        err_digit_d = digit_idx;
      end else begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (sel[i]) begin
            shadow_d[4*i +: 4] = pat_val;
            shadow_dash_d[i]   = (pat_kind == PAT_DASH);
            seen_d[i]          = 1'b1;
          end
        end
        if (seen_d == 4'b1111) begin
          digits_d = shadow_d;
          dash_d   = shadow_dash_d;
          valid_d  = 1'b1;
          seen_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q      <= '1;
      stable_q      <= '0;
      shadow_q      <= '1;
      shadow_dash_q <= '1;
      seen_q        <= '0;
      digits_q      <= '1;
      dash_q        <= '1;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
      err_digit_q   <= '0;
    end else begin
      sample_q      <= sample_d;
      stable_q      <= stable_d;
      shadow_q      <= shadow_d;
      shadow_dash_q <= shadow_dash_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      dash_q        <= dash_d;
      valid_q       <= valid_d;
      err_q         <= err_d;
      err_digit_q   <= err_digit_d;
    end
  end

  assign bus.digits    = digits_q;
  assign bus.dash      = dash_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.err_digit = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues the expected frame or
// error event, a negedge monitor pops and checks whenever valid/err rises.
module tb_seg7_scan_decoder;
  localparam int unsigned SC = 4;

  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P1 = 7'b0000110;
  localparam logic [6:0] P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111;
  localparam logic [6:0] P4 = 7'b1100110;
  localparam logic [6:0] P5 = 7'b1101101;
  localparam logic [6:0] P6 = 7'b1111101;
  localparam logic [6:0] P7 = 7'b0000111;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1101111;
  localparam logic [6:0] PDASH = 7'b1000000;
  localparam logic [6:0] PBAD  = 7'b0000001;

  typedef struct {
    bit          is_err;
    int unsigned at;
    logic [15:0] digits;
    logic [3:0]  dash;
    logic [1:0]  errd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;
  exp_t sb[$];
  exp_t got;

  seg7_scan_decoder_if bus_if();

  seg7_scan_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Present digit k with pattern pat for n edges; ev 1 = frame expected, 2 = err expected.
  task automatic show(input int unsigned k, input logic [6:0] pat, input int unsigned n,
                      input int ev = 0, input logic [15:0] d = '0,
                      input logic [3:0] ds = '0, input logic [1:0] ed = '0);
    exp_t e;
    bus_if.an_n  = ~(4'b0001 << k);
    bus_if.seg_n = ~pat;
    if (ev != 0) begin
      e.is_err = (ev == 2);
      e.at     = cyc + 1 + SC;
      e.digits = d;
      e.dash   = ds;
      e.errd   = ed;
      sb.push_back(e);
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] an, input logic [6:0] seg, input int unsigned n);
    bus_if.an_n  = an;
    bus_if.seg_n = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_state;
    chk("rst_digits", 32'(bus_if.digits), 32'h0000FFFF);
    chk("rst_dash", 32'(bus_if.dash), 32'hF);
    chk("rst_valid", 32'(bus_if.valid), 32'h0);
    chk("rst_err", 32'(bus_if.err), 32'h0);
    chk("rst_err_digit", 32'(bus_if.err_digit), 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && (bus_if.valid || bus_if.err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, bus_if.valid, bus_if.err}, 32'h0);
      end else begin
        got = sb.pop_front();
        chk("event_valid", 32'(bus_if.valid), 32'(!got.is_err));
        chk("event_err", 32'(bus_if.err), 32'(got.is_err));
        chk("event_cycle", cyc, got.at);
        if (got.is_err) begin
          chk("err_digit", 32'(bus_if.err_digit), 32'(got.errd));
        end else begin
          chk("frame_digits", 32'(bus_if.digits), 32'(got.digits));
          chk("frame_dash", 32'(bus_if.dash), 32'(got.dash));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus_if.an_n  = '1;
    bus_if.seg_n = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state();
    rst = 1'b0;

    // Basic frame 1,2,3,4
    show(0, P1, 6); show(1, P2, 6); show(2, P3, 6);
    show(3, P4, 6, 1, 16'h4321, 4'h0);

    // Glitched digit 2, then re-shown for exactly the minimum stable period
    show(0, P5, 6); show(1, P6, 6); show(2, P7, 3); show(3, P8, 6);
    show(2, P7, SC, 1, 16'h8765, 4'h0);

    // Dash on digit 1
    show(0, P0, 6); show(1, PDASH, 6); show(2, P2, 6);
    show(3, P9, 6, 1, 16'h92F0, 4'b0010);

    // Undecodable digit 3 gives err, frame waits for a good digit 3
    show(0, P1, 6); show(1, P1, 6); show(2, P1, 6);
    show(3, PBAD, 6, 2, '0, '0, 2'd3);
    show(3, P5, 6, 1, 16'h5111, 4'h0);
    chk("err_digit_held", 32'(bus_if.err_digit), 32'd3);

    // No digit enabled, then two enabled at once: ignored
    idle(4'b1111, ~P8, 20);
    idle(4'b0011, ~P3, 20);
    chk("idle_digits", 32'(bus_if.digits), 32'h5111);
    chk("idle_dash", 32'(bus_if.dash), 32'h0);

    // Reset mid-frame on the edge that would capture digit 2
    show(0, P9, 6); show(1, P8, 6); show(2, P7, SC);
    rst = 1'b1;
    bus_if.an_n  = '1;
    bus_if.seg_n = '1;
    repeat (2) @(negedge clk);
    chk_reset_state();
    rst = 1'b0;

    // Reverse scan order exposes any seen bits surviving the reset
    show(3, P6, 6); show(2, P7, 6); show(1, P8, 6);
    show(0, P9, 6, 1, 16'h6789, 4'h0);

    idle(4'b1111, '1, 10);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
